i2c_target_rx: RTL and testbench
================================

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h1A, is the 7-bit target address this block answers to.
REQ-002 Clk  input  1  sole clock; all state and outputs change on posedge Clk.
REQ-003 Reset  input  1  reset is synchronous and active-low.
REQ-004 I2C_SCLK  input  1  raw bus clock from the initiator, asynchronous to Clk.
REQ-005 I2C_SDAT_IN  input  1  raw bus data, asynchronous to Clk.
REQ-006 SDAT_PULL_LOW  output  1  1 = drive SDA low (open-drain); 0 = release.
REQ-007 rx_data  output  8  last received data byte, MSB first on bus.
REQ-008 rx_valid  output  1  one-Clk pulse, rx_data/rx_index valid.
REQ-009 rx_index  output  2  data byte position in frame: 0, 1, 2, saturating at 3.
REQ-010 addr_match  output  1  high from address ACK until STOP or repeated START.
REQ-011 frame_done  output  1  one-Clk pulse on STOP after at least one ACKed data byte.
REQ-012 busy  output  1  high between START and STOP.

Function
REQ-013 SCL and SDA SHALL each pass a 2-flop synchronizer; all detection uses the synchronized values and their previous-cycle copies.
REQ-014 START SHALL be synced SDA 1->0 while synced SCL is 1; STOP SHALL be synced SDA 0->1 while synced SCL is 1.
REQ-015 Bits SHALL be sampled on the synced SCL rising edge, shifted MSB first.
REQ-016 States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-017 IDLE->ADDR on START; busy=1; bit counter=0; rx_index counter=0.
REQ-018 ADDR: after 8 bits, if bits[7:1]==TARGET_ADDR and bit0==0 (write), go to ADDR_ACK; otherwise go to IGNORE.
REQ-019 ADDR_ACK: assert SDAT_PULL_LOW on the next synced SCL falling edge; release it on the following falling edge; set addr_match; go to DATA.
REQ-020 DATA: after the 8th rising edge, pulse rx_valid in the next Clk with rx_data=byte and rx_index=current count; go to DATA_ACK.
REQ-021 DATA_ACK: drive ACK as in REQ-019; the count increments (saturating at 3) on release; return to DATA.
REQ-022 IGNORE: SDAT_PULL_LOW SHALL stay 0; no rx_valid; wait for STOP or START.
REQ-023 STOP in any state -> IDLE: release SDA, clear busy and addr_match, pulse frame_done if at least one data byte was ACKed.
REQ-024 START in any non-IDLE state (repeated START) -> ADDR: clear the bit counter and addr_match; rx_index continues.
REQ-025 START/STOP take priority over bit sampling in the same Clk.
REQ-026 SDAT_PULL_LOW SHALL only change while synced SCL is 0.
REQ-027 The block SHALL never drive SDA except during an ACK slot.

Reset
REQ-028 While Reset==0 at posedge Clk: state=IDLE; all outputs 0; counters, shift register and rx_data cleared; synchronizer flops set to 1 (bus idle).
REQ-029 Reset mid-frame SHALL release SDA in the same cycle. After release, the block SHALL ignore the bus until a new START.

Structure
REQ-030 A shared package SHALL hold the state enum and the I2C timing/ACK constants; the default TARGET_ADDR SHALL be defined there as the audio codec address.
REQ-031 One sub-module, i2c_sync_edge, SHALL provide the 2-flop synchronizer plus rise/fall outputs and SHALL be instantiated once per line.

Verification
REQ-032 Reset applied, then released, with the bus idle: all outputs stay 0 and the state is IDLE.
REQ-033 Frame 0x34 (0x1A, write), then 0x1E, 0x00, then STOP:
- three ACK slots with SDAT_PULL_LOW=1;
- rx_valid pulses with (0x1E, idx 0) and (0x00, idx 1);
- frame_done pulses once.
REQ-034 Address byte 0x36 (wrong address): no ACK, no rx_valid, addr_match=0; STOP -> IDLE with no frame_done.
REQ-035 Address byte 0x35 (read bit set): IGNORE, SDA never driven.
REQ-036 Repeated START after one data byte 0xAA, then 0x34, then 0x55, then STOP: rx_index sequence 0, 1; one frame_done.
REQ-037 Reset asserted during the 5th bit of a data byte: SDAT_PULL_LOW=0 next cycle; the next full frame is received correctly.

Source files
------------

// File: rtl/i2c_target_rx_pkg.sv
// Shared types and constants for the I2C write-only target receiver.
package i2c_target_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    // Audio codec 7-bit bus address.
    localparam logic [6:0] CODEC_ADDR = 7'h1A;
    localparam int unsigned BYTE_BITS = 8;
    localparam logic [2:0] LAST_BIT   = 3'(BYTE_BITS - 1);
    localparam logic [1:0] IDX_MAX    = 2'd3;
    localparam logic       ACK_DRIVE  = 1'b1;

    function automatic logic [1:0] idx_inc_sat(input logic [1:0] idx);
        return (idx == IDX_MAX) ? idx : idx + 2'd1;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one raw bus line, with qualified rise/fall strobes.
module i2c_sync_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic line,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic sync_p0, sync_p1, prev_p2;
    logic vld_p0, vld_p1, vld_p2;

    // Edges are suppressed until the previous-cycle copy holds a real sample,
    // so the forced-idle reset values never look like bus transitions.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            sync_p0 <= line;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
        end
    end

    assign sync = sync_p1;
    assign rise = vld_p2 & sync_p1 & ~prev_p2;
    assign fall = vld_p2 & ~sync_p1 & prev_p2;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C write-only target: matches its address, ACKs every byte, and reports
// received data bytes with their position in the frame.
module i2c_target_rx
    import i2c_target_rx_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = CODEC_ADDR
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       I2C_SCLK,
    input  logic       I2C_SDAT_IN,
    output logic       SDAT_PULL_LOW,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [1:0] rx_index,
    output logic       addr_match,
    output logic       frame_done,
    output logic       busy
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_sync_edge u_scl (
        .Clk   (Clk),
        .Reset (Reset),
        .line  (I2C_SCLK),
        .sync  (scl_s),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda (
        .Clk   (Clk),
        .Reset (Reset),
        .line  (I2C_SDAT_IN),
        .sync  (sda_s),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic       start_det, stop_det;
    logic [7:0] byte_in;

    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic [1:0] idx_cnt;
    logic       ack_on;
    logic       data_acked;

    assign byte_in = {shift_reg, sda_s};

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            idx_cnt       <= '0;
            ack_on        <= 1'b0;
            data_acked    <= 1'b0;
            SDAT_PULL_LOW <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_index      <= '0;
            addr_match    <= 1'b0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            if (stop_det) begin
                state         <= IDLE;
                SDAT_PULL_LOW <= 1'b0;
                ack_on        <= 1'b0;
                busy          <= 1'b0;
                addr_match    <= 1'b0;
                frame_done    <= data_acked;
                data_acked    <= 1'b0;
            end else if (start_det) begin
                // A repeated START keeps the byte position running.
                if (state == IDLE) begin
                    idx_cnt    <= '0;
                    data_acked <= 1'b0;
                end
                state         <= ADDR;
                bit_cnt       <= '0;
                SDAT_PULL_LOW <= 1'b0;
                ack_on        <= 1'b0;
                busy          <= 1'b1;
                addr_match    <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= byte_in[6:0];
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == LAST_BIT) begin
                                state <= (byte_in[7:1] == TARGET_ADDR && !byte_in[0])
                                         ? ADDR_ACK : IGNORE;
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise) begin
                            shift_reg <= byte_in[6:0];
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= byte_in;
                                rx_index <= idx_cnt;
                                rx_valid <= 1'b1;
                                state    <= DATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        // First falling edge opens the ACK slot, the next one closes it.
                        if (scl_fall) begin
                            if (!ack_on) begin
                                SDAT_PULL_LOW <= ACK_DRIVE;
                                ack_on        <= 1'b1;
                                if (state == ADDR_ACK) addr_match <= 1'b1;
                            end else begin
                                SDAT_PULL_LOW <= ~ACK_DRIVE;
                                ack_on        <= 1'b0;
                                bit_cnt       <= '0;
                                state         <= DATA;
                                if (state == DATA_ACK) begin
                                    data_acked <= 1'b1;
                                    idx_cnt    <= idx_inc_sat(idx_cnt);
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: drives I2C frames and checks ACKs, data and framing.
module tb_i2c_target_rx;
    import i2c_target_rx_pkg::*;

    localparam int Q = 5;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       I2C_SCLK = 1'b1;
    logic       I2C_SDAT_IN = 1'b1;
    logic       SDAT_PULL_LOW;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [1:0] rx_index;
    logic       addr_match;
    logic       frame_done;
    logic       busy;

    i2c_target_rx dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .I2C_SCLK      (I2C_SCLK),
        .I2C_SDAT_IN   (I2C_SDAT_IN),
        .SDAT_PULL_LOW (SDAT_PULL_LOW),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_index      (rx_index),
        .addr_match    (addr_match),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    // Bus monitor
    logic       ack_window = 1'b0;
    logic       prev_pull = 1'b0;
    int         ack_cnt = 0;
    int         fd_cnt = 0;
    int         viol = 0;
    logic [9:0] rx_log[$];

    always @(negedge Clk) begin
        if (rx_valid) rx_log.push_back({rx_index, rx_data});
        if (frame_done) fd_cnt++;
        if (SDAT_PULL_LOW && !prev_pull) ack_cnt++;
        if (SDAT_PULL_LOW && !ack_window) viol++;
        if ((SDAT_PULL_LOW != prev_pull) && I2C_SCLK) viol++;
        prev_pull = SDAT_PULL_LOW;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic bus_start();
        I2C_SDAT_IN = 1'b1; wait_clk(Q);
        I2C_SCLK = 1'b1;    wait_clk(Q);
        I2C_SDAT_IN = 1'b0; wait_clk(Q);
        I2C_SCLK = 1'b0;    wait_clk(Q);
    endtask

    task automatic bus_stop();
        I2C_SDAT_IN = 1'b0; wait_clk(Q);
        I2C_SCLK = 1'b1;    wait_clk(Q);
        I2C_SDAT_IN = 1'b1; wait_clk(Q);
        wait_clk(Q);
    endtask

    task automatic send_bit(input logic b, input logic last);
        I2C_SDAT_IN = b; wait_clk(Q);
        I2C_SCLK = 1'b1; wait_clk(2 * Q);
        I2C_SCLK = 1'b0;
        if (last) ack_window = 1'b1;
        wait_clk(Q);
    endtask

    task automatic ack_slot(output logic ack);
        I2C_SDAT_IN = 1'b1; wait_clk(Q);
        I2C_SCLK = 1'b1;    wait_clk(Q);
        ack = SDAT_PULL_LOW; wait_clk(Q);
        I2C_SCLK = 1'b0;    wait_clk(Q);
        ack_window = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == 0);
        ack_slot(ack);
    endtask

    logic ack;
    int   base_rx, base_ack, base_fd;

    task automatic snap();
        base_rx  = rx_log.size();
        base_ack = ack_cnt;
        base_fd  = fd_cnt;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with idle bus
        wait_clk(3);
        check_eq("rst_pull_in_reset", 32'(SDAT_PULL_LOW), 32'd0);
        Reset = 1'b1;
        wait_clk(10);
        check_eq("rst_outs", {21'd0, SDAT_PULL_LOW, rx_data, rx_valid, rx_index, addr_match,
                              frame_done, busy}, 32'd0);
        check_eq("rst_state", 32'(dut.state), 32'(IDLE));

        // Good write frame: 0x34, 0x1E, 0x00
        snap();
        bus_start();
        check_eq("f1_busy", 32'(busy), 32'd1);
        send_byte(8'h34, ack);
        check_eq("f1_addr_ack", 32'(ack), 32'd1);
        check_eq("f1_addr_match", 32'(addr_match), 32'd1);
        send_byte(8'h1E, ack);
        check_eq("f1_d0_ack", 32'(ack), 32'd1);
        send_byte(8'h00, ack);
        check_eq("f1_d1_ack", 32'(ack), 32'd1);
        bus_stop();
        check_eq("f1_acks", 32'(ack_cnt - base_ack), 32'd3);
        check_eq("f1_rx_count", 32'(rx_log.size() - base_rx), 32'd2);
        check_eq("f1_rx0", 32'(rx_log[base_rx]), 32'h01E);
        check_eq("f1_rx1", 32'(rx_log[base_rx + 1]), 32'h100);
        check_eq("f1_frame_done", 32'(fd_cnt - base_fd), 32'd1);
        check_eq("f1_idle", {30'd0, busy, addr_match}, 32'd0);

        // Wrong address 0x36
        snap();
        bus_start();
        send_byte(8'h36, ack);
        check_eq("f2_addr_ack", 32'(ack), 32'd0);
        check_eq("f2_addr_match", 32'(addr_match), 32'd0);
        send_byte(8'h11, ack);
        check_eq("f2_data_ack", 32'(ack), 32'd0);
        bus_stop();
        check_eq("f2_acks", 32'(ack_cnt - base_ack), 32'd0);
        check_eq("f2_rx_count", 32'(rx_log.size() - base_rx), 32'd0);
        check_eq("f2_frame_done", 32'(fd_cnt - base_fd), 32'd0);
        check_eq("f2_state", 32'(dut.state), 32'(IDLE));

        // Read request 0x35
        snap();
        bus_start();
        send_byte(8'h35, ack);
        check_eq("f3_addr_ack", 32'(ack), 32'd0);
        check_eq("f3_state", 32'(dut.state), 32'(IGNORE));
        send_byte(8'hFF, ack);
        bus_stop();
        check_eq("f3_acks", 32'(ack_cnt - base_ack), 32'd0);
        check_eq("f3_rx_count", 32'(rx_log.size() - base_rx), 32'd0);

        // Repeated START: 0x34, 0xAA, Sr, 0x34, 0x55
        snap();
        bus_start();
        send_byte(8'h34, ack);
        send_byte(8'hAA, ack);
        bus_start();
        check_eq("f4_sr_addr_match", 32'(addr_match), 32'd0);
        check_eq("f4_sr_busy", 32'(busy), 32'd1);
        send_byte(8'h34, ack);
        check_eq("f4_sr_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h55, ack);
        bus_stop();
        check_eq("f4_acks", 32'(ack_cnt - base_ack), 32'd4);
        check_eq("f4_rx_count", 32'(rx_log.size() - base_rx), 32'd2);
        check_eq("f4_rx0", 32'(rx_log[base_rx]), 32'h0AA);
        check_eq("f4_rx1", 32'(rx_log[base_rx + 1]), 32'h155);
        check_eq("f4_frame_done", 32'(fd_cnt - base_fd), 32'd1);

        // Reset during 5th bit of data byte 0xC3
        snap();
        bus_start();
        send_byte(8'h34, ack);
        for (int i = 7; i >= 4; i--) send_bit(1'b1 & (8'hC3 >> i), 1'b0);
        I2C_SDAT_IN = 1'b0; wait_clk(Q);
        I2C_SCLK = 1'b1;    wait_clk(Q);
        Reset = 1'b0;
        wait_clk(1);
        check_eq("f5_rst_pull", 32'(SDAT_PULL_LOW), 32'd0);
        check_eq("f5_rst_outs", {23'd0, rx_data, busy}, 32'd0);
        Reset = 1'b1;
        wait_clk(Q);
        I2C_SCLK = 1'b0; wait_clk(Q);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        ack_slot(ack);
        check_eq("f5_no_ack_after_rst", 32'(ack), 32'd0);
        bus_stop();
        check_eq("f5_no_frame_done", 32'(fd_cnt - base_fd), 32'd0);
        check_eq("f5_no_rx", 32'(rx_log.size() - base_rx), 32'd0);
        snap();
        bus_start();
        send_byte(8'h34, ack);
        check_eq("f6_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h77, ack);
        bus_stop();
        check_eq("f6_rx_count", 32'(rx_log.size() - base_rx), 32'd1);
        check_eq("f6_rx0", 32'(rx_log[base_rx]), 32'h077);
        check_eq("f6_frame_done", 32'(fd_cnt - base_fd), 32'd1);

        check_eq("sda_drive_rules", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
